// File: rtl/rf_wb_arbiter_if.sv
// Bus bundle between the write-back sources, the arbiter and the register file write port.
// The arbiter uses the slave modport; sources and the RF side use the master modport.
interface rf_wb_arbiter_if #(
    parameter int unsigned width_p      = 32,
    parameter int unsigned addr_width_p = 5
);
    logic                    int_v_i;
    logic [addr_width_p-1:0] int_addr_i;
    logic [width_p-1:0]      int_data_i;

    logic                    ll_v_i;
    logic [addr_width_p-1:0] ll_addr_i;
    logic [width_p-1:0]      ll_data_i;
    logic                    ll_ready_o;

    logic                    stall_int_o;

    logic                    w_v_o;
    logic [addr_width_p-1:0] w_addr_o;
    logic [width_p-1:0]      w_data_o;

    logic                    sb_clr_v_o;
    logic [addr_width_p-1:0] sb_clr_addr_o;
    logic                    fifo_empty_o;

    modport slave (
        input  int_v_i, int_addr_i, int_data_i,
        input  ll_v_i, ll_addr_i, ll_data_i,
        output ll_ready_o, stall_int_o,
        output w_v_o, w_addr_o, w_data_o,
        output sb_clr_v_o, sb_clr_addr_o, fifo_empty_o
    );

    modport master (
        output int_v_i, int_addr_i, int_data_i,
        output ll_v_i, ll_addr_i, ll_data_i,
        input  ll_ready_o, stall_int_o,
        input  w_v_o, w_addr_o, w_data_o,
        input  sb_clr_v_o, sb_clr_addr_o, fifo_empty_o
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter: fixed-priority pipeline writes, buffered long-latency
// returns with scoreboard clears, and a starvation-driven pipeline stall request.
module rf_wb_arbiter #(
    parameter int unsigned width_p        = 32,
    parameter int unsigned els_p          = 32,
    parameter int unsigned fifo_els_p     = 4,
    parameter int unsigned starve_limit_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    rf_wb_arbiter_if.slave     bus
);
    localparam int unsigned addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned ptr_w_lp      = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
    localparam int unsigned cnt_w_lp      = $clog2(fifo_els_p + 1);
    localparam int unsigned starve_w_lp   = $clog2(starve_limit_p + 1);

    typedef logic [addr_width_lp-1:0] addr_t;
    typedef logic [width_p-1:0]       data_t;
    typedef logic [ptr_w_lp-1:0]      ptr_t;
    typedef logic [cnt_w_lp-1:0]      cnt_t;
    typedef logic [starve_w_lp-1:0]   starve_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } ll_entry_t;

    localparam ptr_t    last_ptr_lp   = ptr_t'(fifo_els_p - 1);
    localparam cnt_t    full_cnt_lp   = cnt_t'(fifo_els_p);
    localparam starve_t starve_max_lp = starve_t'(starve_limit_p);

    ll_entry_t mem_q [fifo_els_p];
    ll_entry_t mem_d [fifo_els_p];
    ptr_t      wr_ptr_q, wr_ptr_d;
    ptr_t      rd_ptr_q, rd_ptr_d;
    cnt_t      count_q, count_d;
    starve_t   starve_q, starve_d;
    logic      stall_q, stall_d;

    logic      full_c;
    logic      empty_c;
    logic      ll_ready_c;
    logic      ll_fire_c;
    logic      ll_nz_c;
    logic      int_win_c;
    logic      head_win_c;
    logic      bypass_win_c;
    logic      enq_c;
    logic      deq_c;
    ll_entry_t head_c;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == last_ptr_lp) ? '0 : ptr_t'(p + ptr_t'(1));
    endfunction

    // Per-cycle winner selection; ready depends on registered occupancy only.
    always_comb begin
        full_c       = (count_q == full_cnt_lp);
        empty_c      = (count_q == '0);
        head_c       = mem_q[rd_ptr_q];
        ll_ready_c   = !reset_i && !full_c;
        ll_fire_c    = bus.ll_v_i && ll_ready_c;
        ll_nz_c      = (bus.ll_addr_i != '0);
        int_win_c    = !reset_i && bus.int_v_i && (bus.int_addr_i != '0);
        head_win_c   = !reset_i && !int_win_c && !empty_c;
        bypass_win_c = !int_win_c && empty_c && ll_fire_c && ll_nz_c;
        deq_c        = head_win_c;
        // x0 returns complete the handshake but are never stored.
        enq_c        = ll_fire_c && ll_nz_c && !bypass_win_c;
    end

    // RF write port and scoreboard clear muxing.
    always_comb begin
        bus.w_v_o         = int_win_c || head_win_c || bypass_win_c;
        bus.w_addr_o      = '0;
        bus.w_data_o      = '0;
        bus.sb_clr_v_o    = head_win_c || bypass_win_c;
        bus.sb_clr_addr_o = '0;
        if (int_win_c) begin
            bus.w_addr_o = bus.int_addr_i;
            bus.w_data_o = bus.int_data_i;
        end else if (head_win_c) begin
            bus.w_addr_o      = head_c.addr;
            bus.w_data_o      = head_c.data;
            bus.sb_clr_addr_o = head_c.addr;
        end else if (bypass_win_c) begin
            bus.w_addr_o      = bus.ll_addr_i;
            bus.w_data_o      = bus.ll_data_i;
            bus.sb_clr_addr_o = bus.ll_addr_i;
        end
    end

    assign bus.ll_ready_o   = ll_ready_c;
    assign bus.fifo_empty_o = empty_c;
    assign bus.stall_int_o  = stall_q;

    // FIFO bookkeeping and head starvation tracking.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        starve_d = starve_q;
        stall_d  = 1'b0;

        if (enq_c) begin
            mem_d[wr_ptr_q].addr = bus.ll_addr_i;
            mem_d[wr_ptr_q].data = bus.ll_data_i;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        if (deq_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({enq_c, deq_c})
            2'b10:   count_d = cnt_t'(count_q + cnt_t'(1));
            2'b01:   count_d = cnt_t'(count_q - cnt_t'(1));
            default: count_d = count_q;
        endcase

        if (deq_c || empty_c) begin
            starve_d = '0;
        end else if (starve_q != starve_max_lp) begin
            starve_d = starve_t'(starve_q + starve_t'(1));
        end
        stall_d = (starve_d == starve_max_lp) && !deq_c;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Payload storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifndef SYNTHESIS
    // Interface contract checks against the pipeline and the scoreboard.
    always @(posedge clk_i) begin
        if (!reset_i) begin
            if (stall_q && bus.int_v_i)
                $error("rf_wb_arbiter: int_v_i asserted while stall_int_o is high");
            if (ll_fire_c && $isunknown(bus.ll_addr_i))
                $error("rf_wb_arbiter: long-latency return accepted with unknown address");
            if (deq_c && empty_c)
                $error("rf_wb_arbiter: FIFO underflow");
            if (enq_c && full_c && !deq_c)
                $error("rf_wb_arbiter: FIFO overflow");
            if (int_win_c) begin
                if (bus.ll_v_i && (bus.ll_addr_i == bus.int_addr_i))
                    $error("rf_wb_arbiter: int write collides with incoming ll address");
                for (int k = 0; k < int'(fifo_els_p); k++) begin
                    if ((k < int'(count_q)) &&
                        (mem_q[ptr_t'((int'(rd_ptr_q) + k) % int'(fifo_els_p))].addr
                         == bus.int_addr_i))
                        $error("rf_wb_arbiter: int write collides with buffered ll address");
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed stimulus pushes expected RF writes,
// a negedge monitor pops and compares every write the DUT presents.
module tb_rf_wb_arbiter;
    logic clk;
    logic reset;

    rf_wb_arbiter_if #(.width_p(32), .addr_width_p(5)) bus ();

    rf_wb_arbiter #(
        .width_p(32), .els_p(32), .fifo_els_p(4), .starve_limit_p(8)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        clr;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] d, input logic c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.clr  = c;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [4:0] ia, input logic [31:0] id,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        bus.int_v_i    = iv;
        bus.int_addr_i = ia;
        bus.int_data_i = id;
        bus.ll_v_i     = lv;
        bus.ll_addr_i  = la;
        bus.ll_data_i  = ld;
    endtask

    // Monitor: every RF write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.w_v_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%0h expected no write",
                         bus.w_addr_o, bus.w_data_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("w_addr", 32'(bus.w_addr_o), 32'(e.addr));
                chk("w_data", bus.w_data_o, e.data);
                chk("sb_clr_v", 32'(bus.sb_clr_v_o), 32'(e.clr));
                if (e.clr) chk("sb_clr_addr", 32'(bus.sb_clr_addr_o), 32'(e.addr));
            end
        end else if (bus.sb_clr_v_o) begin
            checks++;
            errors++;
            $display("FAIL sb_clr_without_write: got sb_clr addr=%0d expected none",
                     bus.sb_clr_addr_o);
        end
    end

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        step();
        // Outputs forced low while reset is held, even with live sources.
        drive(1, 5'd3, 32'h55, 1, 5'd5, 32'h66);
        #1;
        chk("rst_w_v", 32'(bus.w_v_o), 0);
        chk("rst_ll_ready", 32'(bus.ll_ready_o), 0);
        chk("rst_sb_clr_v", 32'(bus.sb_clr_v_o), 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post_rst_empty", 32'(bus.fifo_empty_o), 1);
        chk("post_rst_stall", 32'(bus.stall_int_o), 0);
        chk("post_rst_ready", 32'(bus.ll_ready_o), 1);
        step();

        // Bypass with an empty FIFO.
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF);
        push(5'd5, 32'hDEADBEEF, 1);
        #1;
        chk("byp_ready", 32'(bus.ll_ready_o), 1);
        chk("byp_empty", 32'(bus.fifo_empty_o), 1);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("byp_empty_after", 32'(bus.fifo_empty_o), 1);
        step();

        // Collision: int wins, ll buffered and written next cycle.
        drive(1, 5'd3, 32'h11, 1, 5'd7, 32'h22);
        push(5'd3, 32'h11, 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        push(5'd7, 32'h22, 1);
        #1;
        chk("col_not_empty", 32'(bus.fifo_empty_o), 0);
        step();
        #1;
        chk("col_empty_after", 32'(bus.fifo_empty_o), 1);

        // Fill under continuous int writes, then drain in order.
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(10 + i), 32'h100 + 32'(i), 1, 5'(i + 1), 32'h200 + 32'(i));
            push(5'(10 + i), 32'h100 + 32'(i), 0);
            #1;
            chk("fill_ready", 32'(bus.ll_ready_o), 1);
            step();
        end
        drive(1, 5'd20, 32'h120, 1, 5'd9, 32'hBAD);
        push(5'd20, 32'h120, 0);
        #1;
        chk("full_ready", 32'(bus.ll_ready_o), 0);
        chk("full_not_empty", 32'(bus.fifo_empty_o), 0);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            push(5'(i + 1), 32'h200 + 32'(i), 1);
            #1;
            chk("drain_ready", 32'(bus.ll_ready_o), (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        #1;
        chk("drain_empty", 32'(bus.fifo_empty_o), 1);

        // Starvation: one entry held back by 9 cycles of int writes.
        drive(1, 5'd12, 32'h300, 1, 5'd6, 32'h600);
        push(5'd12, 32'h300, 0);
        step();
        for (int k = 1; k <= 8; k++) begin
            drive(1, 5'(12 + k), 32'h300 + 32'(k), 0, 0, 0);
            push(5'(12 + k), 32'h300 + 32'(k), 0);
            #1;
            chk("starve_no_stall", 32'(bus.stall_int_o), 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0);
        push(5'd6, 32'h600, 1);
        #1;
        chk("starve_stall", 32'(bus.stall_int_o), 1);
        step();
        #1;
        chk("starve_release", 32'(bus.stall_int_o), 0);
        chk("starve_empty", 32'(bus.fifo_empty_o), 1);

        // x0 handling: int to r0 does not block the head; ll to r0 is swallowed.
        drive(1, 5'd1, 32'h1, 1, 5'd9, 32'h900);
        push(5'd1, 32'h1, 0);
        step();
        drive(1, 5'd0, 32'h999, 0, 0, 0);
        push(5'd9, 32'h900, 1);
        step();
        drive(0, 0, 0, 1, 5'd0, 32'h777);
        #1;
        chk("x0_ready", 32'(bus.ll_ready_o), 1);
        chk("x0_no_write", 32'(bus.w_v_o), 0);
        chk("x0_no_clr", 32'(bus.sb_clr_v_o), 0);
        step();
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("x0_empty", 32'(bus.fifo_empty_o), 1);
        step();

        // Reset with three buffered entries discards them.
        for (int i = 0; i < 3; i++) begin
            drive(1, 5'(20 + i), 32'h400 + 32'(i), 1, 5'(11 + i), 32'h500 + 32'(i));
            push(5'(20 + i), 32'h400 + 32'(i), 0);
            step();
        end
        reset = 1'b1;
        drive(0, 0, 0, 1, 5'd15, 32'h515);
        #1;
        chk("mid_rst_w_v", 32'(bus.w_v_o), 0);
        chk("mid_rst_ready", 32'(bus.ll_ready_o), 0);
        chk("mid_rst_sb_clr", 32'(bus.sb_clr_v_o), 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("mid_rst_empty", 32'(bus.fifo_empty_o), 1);
        chk("mid_rst_ready_after", 32'(bus.ll_ready_o), 1);
        chk("mid_rst_stall", 32'(bus.stall_int_o), 0);
        for (int i = 0; i < 4; i++) step();

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
Write-back arbiter that sits directly upstream of the integer register file's single synchronous write port. It merges two sources into one RF write per cycle:
- in-order pipeline write-backs, which have fixed priority and no backpressure;
- long-latency returns (remote loads, divides), buffered in a small FIFO.

On every long-latency commit it emits a scoreboard-clear. If the FIFO head waits too long behind pipeline writes, it raises a stall request to the pipeline.

Parameters:
width_p, 32, RF data width
els_p, 32, number of RF entries
addr_width_lp, `BSG_SAFE_CLOG2(els_p), RF address width (derived)
fifo_els_p, 4, long-latency buffer depth (>=2)
starve_limit_p, 8, consecutive non-dequeue cycles with FIFO non-empty before stall request (>=1)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
int_v_i  in  1  pipeline write-back valid (no ready; always accepted)
int_addr_i  in  addr_width_lp  pipeline write-back register
int_data_i  in  width_p  pipeline write-back data
ll_v_i  in  1  long-latency return valid
ll_addr_i  in  addr_width_lp  long-latency destination register
ll_data_i  in  width_p  long-latency data
ll_ready_o  out  1  long-latency return accepted when ll_v_i & ll_ready_o
stall_int_o  out  1  registered; pipeline must hold int_v_i=0 next cycle while high
w_v_o  out  1  RF write enable
w_addr_o  out  addr_width_lp  RF write address
w_data_o  out  width_p  RF write data
sb_clr_v_o  out  1  scoreboard clear for a committed long-latency write
sb_clr_addr_o  out  addr_width_lp  register being cleared
fifo_empty_o  out  1  no buffered long-latency writes

Behaviour:
- Clock and reset: one clock, clk_i. Reset is reset_i, synchronous, active-high.
- Reset values and effects:
  - FIFO emptied; starvation counter=0; stall_int_o=0.
  - While reset_i is high, w_v_o, sb_clr_v_o and ll_ready_o are forced 0.
  - fifo_empty_o=1 from the first cycle after reset.
  - Reset mid-operation discards all buffered entries. No scoreboard clears are issued for them; the scoreboard is reset in the same cycle.
- Timing:
  - w_*, sb_clr_*, ll_ready_o are combinational in the current cycle.
  - ll_ready_o depends only on registered state (= !full); there is no ready-on-valid path.
  - Zero-cycle latency from source valid to RF write.
- Register x0:
  - int writes to address 0 are dropped and do not occupy the port.
  - ll returns to address 0 are accepted (handshake completes), discarded, and produce no sb_clr.
- Per-cycle priority:
  1. int_v_i & int_addr_i!=0 -> write int. The FIFO head waits; an incoming ll is enqueued if ready.
  2. else FIFO non-empty -> write head, dequeue, sb_clr for the head's address. An incoming ll is enqueued if ready; simultaneous enq+deq while full is not possible because ready=!full.
  3. else ll_v_i & ll_ready_o & ll_addr_i!=0 -> bypass: write ll directly, no enqueue, sb_clr.
  4. else w_v_o=0.
- FIFO ordering: FIFO order equals acceptance order; a bypass never overtakes a buffered entry, because rule 3 requires the FIFO to be empty. Enqueue and dequeue in the same cycle are allowed; count is unchanged.
- Starvation counter: width clog2(starve_limit_p+1).
  - Cleared on any dequeue or when empty.
  - Otherwise increments, saturating at starve_limit_p.
  - stall_int_o <= (next counter == starve_limit_p) & !dequeue_this_cycle.
  - Hence stall asserts the cycle after the limit is hit and deasserts the cycle after the head drains.
  - While stall_int_o=1, int_v_i must be 0 (simulation assertion). Rule 2 therefore wins and drains one entry per cycle.
- Hazard contract:
  - The scoreboard guarantees int_addr_i never matches a buffered or incoming ll address (simulation assertion). The arbiter does not compare addresses.
  - Same-cycle RF read/write forwarding is handled downstream by the RF wrapper.
- Assertions (translate_off):
  - ll_v_i & ll_ready_o on an X address flags an error.
  - Any underflow or overflow flags an error.

Test Plan:
- Bypass: FIFO empty, int_v_i=0, ll_v_i=1 addr=5 data=0xDEADBEEF -> same cycle w_v_o=1 addr=5 data=0xDEADBEEF, sb_clr_v_o=1 addr=5, fifo_empty_o stays 1.
- Collision: int addr=3 data=0x11 and ll addr=7 data=0x22 in the same cycle -> cycle0 writes r3=0x11. Cycle1 (int idle) writes r7=0x22 with sb_clr addr=7.
- Fill and order: 4 ll returns (addr 1,2,3,4) under continuous int writes -> ll_ready_o=0 after the 4th acceptance. When int stops, writes go 1,2,3,4 in consecutive cycles, each with sb_clr, and ll_ready_o returns 1 after the first dequeue.
- Starvation: starve_limit_p=8, one buffered entry, int_v_i=1 every cycle -> stall_int_o rises 9 cycles after the enqueue. When int_v_i drops, the entry is written and stall_int_o falls the following cycle.
- x0: int addr=0 with ll addr=9 buffered -> r9 written that cycle. ll to addr 0 -> handshake completes with no w_v_o and no sb_clr.
- Reset mid-flight: 3 entries buffered, reset_i for 1 cycle -> w_v_o=0 during reset. Afterwards fifo_empty_o=1, ll_ready_o=1, stall_int_o=0, and no stale writes appear.
